// File: rtl/matmul_pkg.sv
// Shared constants, state encoding and element-index helpers for the 2x2 matmul sequencer.
package matmul_pkg;

    localparam int DEF_ELEM_W = 4;
    localparam int DEF_ACC_W  = 2*DEF_ELEM_W + 1;
    localparam int N_STEPS    = 8;
    localparam int STEP_W     = $clog2(N_STEPS);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MAC  = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef logic [STEP_W-1:0] step_t;

    // Flat element index is row*2 + col, matching the {x11,x10,x01,x00} packing.
    function automatic logic [1:0] a_index(input step_t k);
        return {k[2], k[0]};
    endfunction

    // B walks down a column: b00, b10, b01, b11 for k[1:0] = 0..3.
    function automatic logic [1:0] b_index(input step_t k);
        return {k[0], k[1]};
    endfunction

endpackage

// File: rtl/matmul_elem_sel.sv
// Step-indexed element mux for one packed 2x2 operand; IS_B selects the B walk order.
module matmul_elem_sel
    import matmul_pkg::*;
#(
    parameter int ELEM_W = DEF_ELEM_W,
    parameter bit IS_B   = 1'b0
) (
    input  logic [4*ELEM_W-1:0] matrix,
    input  step_t               step,
    output logic [ELEM_W-1:0]   elem
);

    logic [3:0][ELEM_W-1:0] elems;
    logic [1:0]             idx;

    assign elems = matrix;
    assign idx   = IS_B ? b_index(step) : a_index(step);
    assign elem  = elems[idx];

endmodule

// File: rtl/matmul_sequencer.sv
// 2x2 x 2x2 matrix multiply over one shared multiplier, one MAC per cycle for 8 steps.
// Optional MATMUL_ABORT_EN adds an abort input that cancels an operation in flight.
module matmul_sequencer
    import matmul_pkg::*;
#(
    parameter int ELEM_W = DEF_ELEM_W,
    parameter int ACC_W  = DEF_ACC_W
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [4*ELEM_W-1:0] matrixA,
    input  logic [4*ELEM_W-1:0] matrixB,
`ifdef MATMUL_ABORT_EN
    input  logic                abort,
`endif
    output logic                busy,
    output logic                done,
    output logic                result_valid,
    output logic [4*ACC_W-1:0]  result,
    output logic [STEP_W-1:0]   entry_out
);

    state_t                 state, state_nxt;
    step_t                  step;
    logic [4*ELEM_W-1:0]    op_a, op_b;
    logic [ELEM_W-1:0]      a_el, b_el;
    logic [2*ELEM_W-1:0]    prod, acc;
    logic [3:0][ACC_W-1:0]  res_q;
    logic                   rv_q;
    logic                   abort_req, abort_hit, start_acc, last_step;

`ifdef MATMUL_ABORT_EN
    assign abort_req = abort;
`else
    assign abort_req = 1'b0;
`endif

    // Abort outranks start, so a start in the same cycle is dropped.
    assign abort_hit = abort_req && (state != IDLE);
    assign start_acc = start && !abort_req && (state == IDLE);
    assign last_step = (step == step_t'(N_STEPS-1));

    matmul_elem_sel #(.ELEM_W(ELEM_W), .IS_B(1'b0)) u_sel_a (
        .matrix (op_a),
        .step   (step),
        .elem   (a_el)
    );

    matmul_elem_sel #(.ELEM_W(ELEM_W), .IS_B(1'b1)) u_sel_b (
        .matrix (op_b),
        .step   (step),
        .elem   (b_el)
    );

    assign prod = {{ELEM_W{1'b0}}, a_el} * {{ELEM_W{1'b0}}, b_el};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start_acc) state_nxt = MAC;
            MAC:     if (abort_hit) state_nxt = IDLE;
                     else if (last_step) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy      = 1'b0;
        done      = 1'b0;
        entry_out = '0;
        case (state)
            MAC: begin
                busy      = 1'b1;
                entry_out = step;
            end
            DONE: begin
                busy = 1'b1;
                done = !abort_req;
            end
            default: ;
        endcase
    end

    // Even steps park the first product; odd steps retire one result entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_a  <= '0;
            op_b  <= '0;
            step  <= '0;
            acc   <= '0;
            res_q <= '0;
            rv_q  <= 1'b0;
        end else if (abort_hit) begin
            step  <= '0;
            acc   <= '0;
            res_q <= '0;
            rv_q  <= 1'b0;
        end else if (start_acc) begin
            op_a  <= matrixA;
            op_b  <= matrixB;
            step  <= '0;
            acc   <= '0;
            res_q <= '0;
            rv_q  <= 1'b0;
        end else if (state == MAC) begin
            step <= step + step_t'(1);
            if (!step[0]) acc <= prod;
            else          res_q[step[2:1]] <= ACC_W'(acc) + ACC_W'(prod);
            if (last_step) rv_q <= 1'b1;
        end
    end

    assign result_valid = rv_q && !abort_hit;
    assign result       = res_q;

endmodule

// File: tb/tb_matmul_sequencer.sv
// Bench for matmul_sequencer: phase-level reference model compared every cycle, plus literal pins.
module tb_matmul_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [15:0] matrixA = '0, matrixB = '0;
    logic        busy, done, result_valid;
    logic [35:0] result;
    logic [2:0]  entry_out;

    int n_checks = 0;
    int n_errs   = 0;

    always #5 clk = ~clk;

    matmul_sequencer dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .matrixA      (matrixA),
        .matrixB      (matrixB),
`ifdef MATMUL_ABORT_EN
        .abort        (abort),
`endif
        .busy         (busy),
        .done         (done),
        .result_valid (result_valid),
        .result       (result),
        .entry_out    (entry_out)
    );

    // Plain matrix product: c[i][j] = sum_k a[i][k]*b[k][j], flat index row*2+col.
    function automatic logic [3:0][8:0] mat_mul(input logic [15:0] a, input logic [15:0] b);
        logic [3:0][8:0] c;
        for (int i = 0; i < 2; i++)
            for (int j = 0; j < 2; j++) begin
                int s;
                s = 0;
                for (int k = 0; k < 2; k++)
                    s += int'(a[(i*2+k)*4 +: 4]) * int'(b[(k*2+j)*4 +: 4]);
                c[i*2+j] = 9'(s);
            end
        return c;
    endfunction

    // Model: m_t = 0 idle, 1..8 MAC cycle, 9 done cycle. Entry e becomes visible from phase 2e+3.
    int              m_t;
    logic [3:0][8:0] m_c, m_res;
    logic            m_rv;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_t   <= 0;
            m_c   <= '0;
            m_res <= '0;
            m_rv  <= 1'b0;
        end else if (abort && m_t != 0) begin
            m_t   <= 0;
            m_res <= '0;
            m_rv  <= 1'b0;
        end else if (m_t == 0) begin
            if (start && !abort) begin
                m_t   <= 1;
                m_c   <= mat_mul(matrixA, matrixB);
                m_res <= '0;
                m_rv  <= 1'b0;
            end
        end else begin
            m_t <= (m_t == 9) ? 0 : m_t + 1;
            for (int e = 0; e < 4; e++)
                if (m_t + 1 >= 2*e + 3) m_res[e] <= m_c[e];
            if (m_t == 8) m_rv <= 1'b1;
        end
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errs++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic compare();
        logic [2:0] e_ent;
        e_ent = (m_t >= 1 && m_t <= 8) ? 3'(m_t - 1) : 3'd0;
        chk("busy", busy, m_t != 0);
        chk("done", done, (m_t == 9) && !abort);
        chk("entry_out", entry_out, e_ent);
        chk("result_valid", result_valid, m_rv && !(abort && m_t != 0));
        chk("result", result, m_res);
    endtask

    task automatic tick();
        @(negedge clk);
        compare();
    endtask

    // One operation from IDLE; operand inputs are scrambled after acceptance.
    task automatic run_op(input logic [15:0] a, input logic [15:0] b, output int lat);
        matrixA = a;
        matrixB = b;
        start   = 1'b1;
        tick();
        start   = 1'b0;
        matrixA = 16'($urandom);
        matrixB = 16'($urandom);
        lat = 1;
        while (!done && lat < 20) begin
            if (lat <= 8) chk("entry_step", entry_out, 64'(lat - 1));
            tick();
            lat++;
        end
        if (!done) chk("done_timeout", done, 1);
        tick();
    endtask

    initial begin
        int lat, cnt;
        logic [15:0] ra, rb;

        // Reset
        tick();
        chk("reset_result", result, 0);
        chk("reset_busy", busy, 0);
        chk("reset_rv", result_valid, 0);
        rst_n = 1'b1;
        tick();

        // Identity times B
        run_op(16'h1001, 16'h4321, lat);
        chk("t1_latency", lat, 9);
        chk("t1_result", result, {9'd4, 9'd3, 9'd2, 9'd1});
        chk("t1_model", m_res, {9'd4, 9'd3, 9'd2, 9'd1});
        chk("t1_rv", result_valid, 1);
        repeat (3) tick();
        chk("t1_hold", result, {9'd4, 9'd3, 9'd2, 9'd1});

        // Max operands
        run_op(16'hFFFF, 16'hFFFF, lat);
        chk("t2_result", result, {4{9'h1C2}});
        chk("t2_model", m_res, {4{9'h1C2}});

        // General case
        run_op(16'h4321, 16'h8765, lat);
        chk("t3_result", result, {9'd50, 9'd43, 9'd22, 9'd19});
        chk("t3_model", m_res, {9'd50, 9'd43, 9'd22, 9'd19});

        // Start pulses at cycles 3 and 9 are ignored
        matrixA = 16'h2222; matrixB = 16'h3333;
        start = 1'b1; tick(); start = 1'b0;
        cnt = 0;
        tick(); cnt += int'(done);
        tick(); cnt += int'(done);
        start = 1'b1; tick(); start = 1'b0; cnt += int'(done);
        repeat (5) begin tick(); cnt += int'(done); end
        chk("t4_done_c9", done, 1);
        start = 1'b1; tick(); start = 1'b0; cnt += int'(done);
        chk("t4_idle_c10", busy, 0);
        repeat (4) begin tick(); cnt += int'(done); end
        chk("t4_one_done", cnt, 1);
        chk("t4_result", result, {9'd12, 9'd12, 9'd12, 9'd12});
        run_op(16'h4321, 16'h8765, lat);
        chk("t4_next_latency", lat, 9);

        // Start held: restarts every 10 cycles
        matrixA = 16'h1111; matrixB = 16'h1111;
        start = 1'b1;
        cnt = 0;
        repeat (20) begin tick(); cnt += int'(done); end
        start = 1'b0;
        chk("held_dones", cnt, 2);
        chk("held_idle", busy, 0);
        tick();

        // Reset mid-MAC
        matrixA = 16'h9876; matrixB = 16'h5432;
        start = 1'b1; tick(); start = 1'b0;
        repeat (4) tick();
        chk("t5_pre_entry", entry_out, 4);
        rst_n = 1'b0;
        #1;
        chk("t5_busy", busy, 0);
        chk("t5_done", done, 0);
        chk("t5_rv", result_valid, 0);
        chk("t5_result", result, 0);
        chk("t5_entry", entry_out, 0);
        cnt = 0;
        repeat (3) begin tick(); cnt += int'(done); end
        rst_n = 1'b1;
        repeat (3) begin tick(); cnt += int'(done); end
        chk("t5_no_done", cnt, 0);
        run_op(16'h4321, 16'h8765, lat);
        chk("t5_after", result, {9'd50, 9'd43, 9'd22, 9'd19});

`ifdef MATMUL_ABORT_EN
        matrixA = 16'hFFFF; matrixB = 16'hFFFF;
        start = 1'b1; tick(); start = 1'b0;
        repeat (5) tick();
        abort = 1'b1; tick(); abort = 1'b0;
        chk("t6_busy", busy, 0);
        chk("t6_result", result, 0);
        chk("t6_rv", result_valid, 0);
        cnt = 0;
        repeat (10) begin tick(); cnt += int'(done); end
        chk("t6_no_done", cnt, 0);
        abort = 1'b1; start = 1'b1; tick(); abort = 1'b0; start = 1'b0;
        chk("t6_abort_start", busy, 0);
        tick();
`endif

        // Randomized operations with idle gaps
        for (int i = 0; i < 30; i++) begin
            ra = (i % 7 == 0) ? 16'hFFFF : 16'($urandom);
            rb = (i % 5 == 0) ? 16'hFFFF : 16'($urandom);
            run_op(ra, rb, lat);
            chk("rand_latency", lat, 9);
            repeat ($urandom_range(0, 3)) tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

endmodule
